// File: rtl/ssd_pkg.sv
// Shared definitions for the multiplexed seven-segment scan driver:
// active-low glyph constants {a,b,c,d,e,f,g}, slot phase type and the
// nibble-to-glyph helper.
package ssd_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] BRIGHT_FULL = 4'd15;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_SHOW  = 1'b1
    } slot_phase_e;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] glyph;
        case (nib)
            4'h0:    glyph = SEG_0;
            4'h1:    glyph = SEG_1;
            4'h2:    glyph = SEG_2;
            4'h3:    glyph = SEG_3;
            4'h4:    glyph = SEG_4;
            4'h5:    glyph = SEG_5;
            4'h6:    glyph = SEG_6;
            4'h7:    glyph = SEG_7;
            4'h8:    glyph = SEG_8;
            4'h9:    glyph = SEG_9;
            4'hA:    glyph = SEG_A;
            4'hB:    glyph = SEG_B;
            4'hC:    glyph = SEG_C;
            4'hD:    glyph = SEG_D;
            4'hE:    glyph = SEG_E;
            4'hF:    glyph = SEG_F;
            default: glyph = SEG_BLANK;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment glyph.
module ssd_hex_decoder
    import ssd_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    // Map the nibble onto its glyph.
    always_comb begin
        o_seg = hex_to_seg(i_nibble);
    end

endmodule

// File: rtl/ssd_scan_driver.sv
// N-digit multiplexed seven-segment scan driver with tear-free updates
// (new data taken only at frame boundaries) and a blanking gap at the
// start of every digit slot. Optional macro SSD_DIM_EN adds a 4-bit
// brightness input that shortens the lit part of each SHOW window.
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 16,
    parameter int BLANK_CYCLES = 2
)
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic [4*NUM_DIGITS-1:0]   digit_data,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     digit_en,
    input  logic                      load,
`ifdef SSD_DIM_EN
    input  logic [3:0]                brightness,
`endif
    output logic [NUM_DIGITS-1:0]     anodes,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic                      frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{1'b1}};
    localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1'b1);

    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    slot_phase_e             r_phase;
    logic [4*NUM_DIGITS-1:0] r_act_data;
    logic [NUM_DIGITS-1:0]   r_act_dp;
    logic [4*NUM_DIGITS-1:0] r_shd_data;
    logic [NUM_DIGITS-1:0]   r_shd_dp;
    logic                    r_pending;
`ifdef SSD_DIM_EN
    logic [3:0]              r_act_bright;
    logic [3:0]              r_shd_bright;
    logic [31:0]             w_dim_pos;
    logic [31:0]             w_dim_lim;
`endif

    logic                    w_boundary;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [IDX_W-1:0]        w_idx_nxt;
    slot_phase_e             w_phase_nxt;
    logic [4*NUM_DIGITS-1:0] w_shifted;
    logic [3:0]              w_nibble;
    logic [6:0]              w_seg;
    logic                    w_digit_on;
    logic                    w_dp_bit;
    logic                    w_dim_ok;
    logic                    w_anode_lit;

    ssd_hex_decoder u_dec (
        .i_nibble (w_nibble),
        .o_seg    (w_seg)
    );

    // Next scan position, current digit selection and anode gating.
    always_comb begin
        w_boundary  = (r_cnt == CNT_LAST) && (r_idx == IDX_LAST);
        if (r_cnt == CNT_LAST) begin
            w_cnt_nxt = {CNT_W{1'b0}};
            w_idx_nxt = (r_idx == IDX_LAST) ? {IDX_W{1'b0}} : r_idx + IDX_W'(1);
        end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
            w_idx_nxt = r_idx;
        end
        w_phase_nxt = (32'(w_cnt_nxt) < 32'(BLANK_CYCLES)) ? PH_BLANK : PH_SHOW;
        w_shifted   = r_act_data >> {r_idx, 2'b00};
        w_nibble    = w_shifted[3:0];
        w_digit_on  = digit_en[r_idx];
        w_dp_bit    = r_act_dp[r_idx];
`ifdef SSD_DIM_EN
        w_dim_pos   = (32'(r_cnt) - 32'(BLANK_CYCLES)) << 4;
        w_dim_lim   = (32'(r_act_bright) + 32'd1) * 32'(SCAN_DIV - BLANK_CYCLES);
        w_dim_ok    = (w_dim_pos < w_dim_lim);
`else
        w_dim_ok    = 1'b1;
`endif
        w_anode_lit = (r_phase == PH_SHOW) && w_digit_on && w_dim_ok;
    end

    // Scan counter, slot phase FSM, shadow/active data and registered pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= {CNT_W{1'b0}};
            r_idx        <= {IDX_W{1'b0}};
            r_phase      <= (BLANK_CYCLES > 0) ? PH_BLANK : PH_SHOW;
            r_act_data   <= {(4*NUM_DIGITS){1'b0}};
            r_act_dp     <= {NUM_DIGITS{1'b0}};
            r_shd_data   <= {(4*NUM_DIGITS){1'b0}};
            r_shd_dp     <= {NUM_DIGITS{1'b0}};
            r_pending    <= 1'b0;
`ifdef SSD_DIM_EN
            r_act_bright <= BRIGHT_FULL;
            r_shd_bright <= BRIGHT_FULL;
`endif
            anodes       <= AN_OFF;
            seg          <= SEG_BLANK;
            dp           <= 1'b1;
            frame_done   <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_phase <= w_phase_nxt;

            // A load on the boundary bypasses the shadow entirely.
            if (load && w_boundary) begin
                r_act_data   <= digit_data;
                r_act_dp     <= dp_in;
                r_pending    <= 1'b0;
`ifdef SSD_DIM_EN
                r_act_bright <= brightness;
`endif
            end else if (w_boundary && r_pending) begin
                r_act_data   <= r_shd_data;
                r_act_dp     <= r_shd_dp;
                r_pending    <= 1'b0;
`ifdef SSD_DIM_EN
                r_act_bright <= r_shd_bright;
`endif
            end else if (load) begin
                r_shd_data   <= digit_data;
                r_shd_dp     <= dp_in;
                r_pending    <= 1'b1;
`ifdef SSD_DIM_EN
                r_shd_bright <= brightness;
`endif
            end

            anodes     <= w_anode_lit ? ~(AN_ONE << r_idx) : AN_OFF;
            seg        <= w_digit_on ? w_seg : SEG_BLANK;
            dp         <= w_digit_on ? ~w_dp_bit : 1'b1;
            frame_done <= w_boundary;
        end
    end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Self-checking bench for ssd_scan_driver (4 digits, 8 cycles/slot,
// 2 blanking cycles). A cycle model pushes expected pin values into a
// queue at each rising edge; they are popped and compared on the falling
// edge. Scenario tasks add targeted checks against hand-derived values.
module tb_ssd_scan_driver;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] digit_data = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  digit_en = 4'hF;
    logic        load = 1'b0;
`ifdef SSD_DIM_EN
    logic [3:0]  brightness = 4'd15;
`endif
    logic [3:0]  anodes;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    logic [12:0] sb_q[$];

    int          m_cnt = 0;
    int          m_idx = 0;
    logic [15:0] m_act = 16'h0000;
    logic [15:0] m_shd = 16'h0000;
    logic [3:0]  m_adp = 4'h0;
    logic [3:0]  m_sdp = 4'h0;
    logic        m_pend = 1'b0;
    logic        m_started = 1'b0;
    logic [3:0]  m_br = 4'd15;
    logic [3:0]  m_sbr = 4'd15;

    always #5 clk = ~clk;

    ssd_scan_driver #(
        .NUM_DIGITS   (4),
        .SCAN_DIV     (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .digit_data (digit_data),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .load       (load),
`ifdef SSD_DIM_EN
        .brightness (brightness),
`endif
        .anodes     (anodes),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;
            4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;
            4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;
            4'hF: return 7'b0111000;
            default: return 7'h7F;
        endcase
    endfunction

    // Reference model and scoreboard: predict at the rising edge, compare at the falling edge.
    initial begin : scoreboard
        logic [12:0] e_v;
        logic [12:0] o_v;
        logic [3:0]  an_v;
        logic [3:0]  nib_v;
        logic        en_v;
        logic        lit_v;
        logic        bnd_v;
        forever begin
            @(posedge clk);
            if (reset) begin
                sb_q.push_back({4'hF, 7'h7F, 1'b1, 1'b0});
                m_started = 1'b1;
                m_cnt = 0; m_idx = 0;
                m_act = 16'h0000; m_adp = 4'h0; m_pend = 1'b0;
                m_br = 4'd15;
            end else if (m_started) begin
                en_v  = digit_en[m_idx];
                nib_v = m_act[4*m_idx +: 4];
                lit_v = en_v && (m_cnt >= 2);
`ifdef SSD_DIM_EN
                lit_v = lit_v && (((m_cnt - 2) * 16) < ((int'(m_br) + 1) * 6));
`endif
                an_v  = 4'b0001 << m_idx;
                an_v  = lit_v ? ~an_v : 4'hF;
                bnd_v = (m_cnt == 7) && (m_idx == 3);
                e_v   = {an_v, (en_v ? glyph(nib_v) : 7'h7F),
                         (en_v ? ~m_adp[m_idx] : 1'b1), bnd_v};
                sb_q.push_back(e_v);
                if (load) begin
                    m_shd = digit_data; m_sdp = dp_in; m_pend = 1'b1;
`ifdef SSD_DIM_EN
                    m_sbr = brightness;
`endif
                end
                if (bnd_v && m_pend) begin
                    m_act = m_shd; m_adp = m_sdp; m_pend = 1'b0; m_br = m_sbr;
                end
                m_cnt = m_cnt + 1;
                if (m_cnt == 8) begin
                    m_cnt = 0;
                    m_idx = (m_idx + 1) % 4;
                end
            end
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e_v = sb_q.pop_front();
                o_v = {anodes, seg, dp, frame_done};
                checks++;
                if (o_v !== e_v) begin
                    errors++;
                    $display("FAIL scoreboard t=%0t got an=%h seg=%b dp=%b fd=%b want an=%h seg=%b dp=%b fd=%b",
                             $time, o_v[12:9], o_v[8:2], o_v[1], o_v[0], e_v[12:9], e_v[8:2], e_v[1], e_v[0]);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Advance until just after a frame_done pulse; next edge starts a frame.
    task automatic wait_frame();
        for (int n = 0; n < 40; n++) begin
            cyc();
            if (frame_done === 1'b1) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_frame: no frame_done within 40 cycles");
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if ({anodes, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL reset_state: got an=%h seg=%b dp=%b fd=%b want an=f seg=1111111 dp=1 fd=0",
                         anodes, seg, dp, frame_done);
            end
        end
        reset = 1'b0;
        for (int p = 0; p < 2; p++) begin
            n = 0;
            for (int i = 1; i <= 40; i++) begin
                cyc();
                if (frame_done === 1'b1) begin
                    n = i;
                    break;
                end
            end
            checks++;
            if (n != 32) begin
                errors++;
                $display("FAIL frame_period[%0d]: got %0d cycles want 32", p, n);
            end
        end
    endtask

    task automatic test_pattern();
        logic [6:0] want[4];
        logic [3:0] e_an;
        int k;
        int c;
        want = '{7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
        digit_en = 4'hF; digit_data = 16'h1234; dp_in = 4'b0001; load = 1'b1;
        cyc();
        load = 1'b0;
        wait_frame();
        for (int j = 0; j < 32; j++) begin
            cyc();
            k = j / 8; c = j % 8;
            e_an = 4'b0001 << k;
            e_an = (c < 2) ? 4'hF : ~e_an;
            checks++;
            if ({anodes, seg, dp} !== {e_an, want[k], (k != 0)}) begin
                errors++;
                $display("FAIL pattern_1234 j=%0d: got an=%h seg=%b dp=%b want an=%h seg=%b dp=%b",
                         j, anodes, seg, dp, e_an, want[k], (k != 0));
            end
        end
    endtask

    task automatic test_latest_wins();
        logic [6:0] old_w[4];
        logic [6:0] new_w[4];
        int k;
        old_w = '{7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
        new_w = '{7'b0000000, 7'b0001111, 7'b0100000, 7'b0100100};
        wait_frame();
        for (int j = 0; j < 10; j++) cyc();
        digit_data = 16'hABCD; dp_in = 4'h0; load = 1'b1;
        cyc();
        load = 1'b0;
        cyc();
        digit_data = 16'h5678; load = 1'b1;
        cyc();
        load = 1'b0;
        for (int j = 13; j < 32; j++) begin
            cyc();
            k = j / 8;
            checks++;
            if (seg !== old_w[k]) begin
                errors++;
                $display("FAIL latest_cur_frame j=%0d: got seg=%b want %b", j, seg, old_w[k]);
            end
        end
        for (int j = 0; j < 32; j++) begin
            cyc();
            k = j / 8;
            checks++;
            if ({seg, dp} !== {new_w[k], 1'b1}) begin
                errors++;
                $display("FAIL latest_next_frame j=%0d: got seg=%b dp=%b want seg=%b dp=1", j, seg, dp, new_w[k]);
            end
        end
    endtask

    task automatic test_boundary_load();
        logic [6:0] e_seg;
        wait_frame();
        for (int j = 0; j < 31; j++) cyc();
        digit_data = 16'h00FF; dp_in = 4'h0; load = 1'b1;
        cyc();
        load = 1'b0;
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL boundary_align: got fd=%b want 1", frame_done);
        end
        for (int j = 0; j < 32; j++) begin
            cyc();
            e_seg = (j < 16) ? 7'b0111000 : 7'b0000001;
            checks++;
            if (seg !== e_seg) begin
                errors++;
                $display("FAIL boundary_load j=%0d: got seg=%b want %b", j, seg, e_seg);
            end
        end
    endtask

    task automatic test_digit_en();
        int k;
        digit_en = 4'b1011;
        wait_frame();
        for (int j = 0; j < 32; j++) begin
            cyc();
            k = j / 8;
            checks++;
            if (anodes[2] !== 1'b1) begin
                errors++;
                $display("FAIL digit_en_anode j=%0d: got anodes=%h want bit2=1", j, anodes);
            end
            if (k == 2) begin
                checks++;
                if ({seg, dp} !== {7'h7F, 1'b1}) begin
                    errors++;
                    $display("FAIL digit_en_dark j=%0d: got seg=%b dp=%b want 1111111/1", j, seg, dp);
                end
            end
            checks++;
            if (frame_done !== (j == 31)) begin
                errors++;
                $display("FAIL digit_en_period j=%0d: got fd=%b want %b", j, frame_done, (j == 31));
            end
        end
        digit_en = 4'hF;
    endtask

    task automatic test_reset_mid();
        logic [3:0] e_an;
        int k;
        int c;
        wait_frame();
        for (int j = 0; j < 20; j++) cyc();
        reset = 1'b1; digit_data = 16'h1234; dp_in = 4'hF; load = 1'b1;
        cyc();
        checks++;
        if ({anodes, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_off: got an=%h seg=%b dp=%b fd=%b want f/1111111/1/0",
                     anodes, seg, dp, frame_done);
        end
        reset = 1'b0; load = 1'b0;
        for (int j = 0; j < 64; j++) begin
            cyc();
            k = (j / 8) % 4; c = j % 8;
            e_an = 4'b0001 << k;
            e_an = (c < 2) ? 4'hF : ~e_an;
            checks++;
            if ({anodes, seg, dp, frame_done} !== {e_an, 7'b0000001, 1'b1, ((j % 32) == 31)}) begin
                errors++;
                $display("FAIL reset_mid_restart j=%0d: got an=%h seg=%b dp=%b fd=%b want an=%h seg=0000001 dp=1 fd=%b",
                         j, anodes, seg, dp, frame_done, e_an, ((j % 32) == 31));
            end
        end
    endtask

`ifdef SSD_DIM_EN
    task automatic test_dim();
        int lit[4];
        lit = '{0, 0, 0, 0};
        brightness = 4'd7; digit_data = 16'h1234; load = 1'b1;
        cyc();
        load = 1'b0; brightness = 4'd15;
        wait_frame();
        for (int j = 0; j < 32; j++) begin
            cyc();
            if (anodes !== 4'hF) lit[j / 8]++;
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (lit[k] != 3) begin
                errors++;
                $display("FAIL dim_b7 slot=%0d: got %0d lit cycles want 3", k, lit[k]);
            end
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            load       = ($urandom_range(0, 7) == 0);
            digit_data = 16'($urandom);
            dp_in      = 4'($urandom);
            digit_en   = 4'($urandom);
`ifdef SSD_DIM_EN
            brightness = 4'($urandom);
`endif
            cyc();
        end
        load = 1'b0;
        digit_en = 4'hF;
    endtask

    // Hard stop in case anything stalls.
    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        test_reset();
        test_pattern();
        test_latest_wins();
        test_boundary_load();
        test_digit_en();
        test_reset_mid();
`ifdef SSD_DIM_EN
        test_dim();
`endif
        test_random();
        cyc();
        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
